// File: rtl/baud_detect.sv
// Auto-baud detector: times the first four line edges of a 0x55 sync character
// and converts the measured span into a preset divider code plus a load strobe.
module baud_detect #(
  parameter int CNT_WIDTH  = 8,
  parameter int SYNC_EDGES = 4
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       en,
  input  logic       start,
  input  logic       rx_in,
  output logic [1:0] divisor_sel,
  output logic       divisor_ld,
  output logic       busy,
  output logic       err
);

  localparam int EW = $clog2(SYNC_EDGES + 1);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0]        EDGE_ONE  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0]        EDGE_ZERO = {EW{1'b0}};
  localparam logic [EW-1:0]        EDGE_LAST = EW'(SYNC_EDGES - 1);

  localparam logic [CNT_WIDTH:0] S_LIM_01 = (CNT_WIDTH+1)'(12);
  localparam logic [CNT_WIDTH:0] S_LIM_10 = (CNT_WIDTH+1)'(24);
  localparam logic [CNT_WIDTH:0] S_LIM_11 = (CNT_WIDTH+1)'(48);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    MEASURE = 2'b10,
    DONE    = 2'b11
  } state_t;

  state_t               state_r, state_next_s;
  logic                 sync1_r, sync2_r, sync3_r;
  logic                 edge_r, fall_r;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_next_s;
  logic [EW-1:0]        edges_r, edges_next_s;
  logic [1:0]           sel_r, sel_next_s;
  logic                 ld_r, ld_next_s;
  logic                 err_r, err_next_s;
  logic [CNT_WIDTH:0]   span_s;
  logic                 final_edge_s;

  // Span S is one wider than the counter so an edge on the saturating cycle still reads >= 48.
  function automatic logic [1:0] quantize(input logic [CNT_WIDTH:0] s);
    logic [1:0] code;
    if (s < S_LIM_01) begin
      code = 2'b00;
    end else if (s < S_LIM_10) begin
      code = 2'b01;
    end else if (s < S_LIM_11) begin
      code = 2'b10;
    end else begin
      code = 2'b11;
    end
    return code;
  endfunction

  assign span_s       = {1'b0, cnt_r} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign final_edge_s = edge_r && (edges_r == EDGE_LAST);

  // Line synchronizer and registered edge strobes; frozen together with the FSM while en is low.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      sync3_r <= 1'b1;
      edge_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else if (en) begin
      sync1_r <= rx_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      edge_r  <= sync2_r ^ sync3_r;
      fall_r  <= sync3_r & ~sync2_r;
    end else begin
      sync1_r <= sync1_r;
      sync2_r <= sync2_r;
      sync3_r <= sync3_r;
      edge_r  <= edge_r;
      fall_r  <= fall_r;
    end
  end

  // Measurement FSM state, counters and registered result outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      edges_r <= EDGE_ZERO;
      sel_r   <= 2'b00;
      ld_r    <= 1'b0;
      err_r   <= 1'b0;
    end else if (en) begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      edges_r <= edges_next_s;
      sel_r   <= sel_next_s;
      ld_r    <= ld_next_s;
      err_r   <= err_next_s;
    end else begin
      state_r <= state_r;
      cnt_r   <= cnt_r;
      edges_r <= edges_r;
      sel_r   <= sel_r;
      ld_r    <= ld_r;
      err_r   <= err_r;
    end
  end

  // Next-state logic; the final-edge test precedes the timeout so a coincident edge wins.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    edges_next_s = edges_r;
    sel_next_s   = sel_r;
    ld_next_s    = 1'b0;
    err_next_s   = err_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = ARMED;
          err_next_s   = 1'b0;
          edges_next_s = EDGE_ZERO;
        end else begin
          state_next_s = IDLE;
        end
      end
      ARMED: begin
        if (fall_r) begin
          state_next_s = MEASURE;
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = ARMED;
        end
      end
      MEASURE: begin
        cnt_next_s = cnt_r + CNT_ONE;
        if (edge_r) begin
          edges_next_s = edges_r + EDGE_ONE;
        end else begin
          edges_next_s = edges_r;
        end
        if (final_edge_s) begin
          state_next_s = DONE;
          sel_next_s   = quantize(span_s);
          ld_next_s    = 1'b1;
        end else if (cnt_r == CNT_MAX) begin
          state_next_s = IDLE;
          err_next_s   = 1'b1;
        end else begin
          state_next_s = MEASURE;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  assign divisor_sel = sel_r;
  assign divisor_ld  = ld_r & en;
  assign busy        = (state_r == ARMED) || (state_r == MEASURE);
  assign err         = err_r;

endmodule
